// File: rtl/i2c_bit_ctrl_if.sv
// Command handshake between a byte-level I2C controller (master side)
// and the bit-level engine (slave side).
interface i2c_bit_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       wr_bit;
    logic       cmd_ready;
    logic       done;
    logic       rd_bit;
    logic       arb_lost;

    modport master (
        output cmd_valid, cmd, wr_bit,
        input  cmd_ready, done, rd_bit, arb_lost
    );

    modport slave (
        input  cmd_valid, cmd, wr_bit,
        output cmd_ready, done, rd_bit, arb_lost
    );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master engine: turns START/STOP/WRITE/READ commands into
// open-drain SCL/SDA quarter-period waveforms, with stretching and arbitration.
module i2c_bit_ctrl #(
    parameter int FILTER_LEN = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           tickX4,
    input  logic           tickX16,
    i2c_bit_ctrl_if.slave  bus,
    output logic           bus_busy,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           scl_oe,
    output logic           sda_oe
);

    if (FILTER_LEN < 1 || FILTER_LEN % 2 == 0) begin : gBadFilterLen
        $error("i2c_bit_ctrl: FILTER_LEN must be odd and >= 1");
    end

    typedef enum logic [2:0] {IDLE, WAIT, Q0, Q1, Q2, Q3} state_t;
    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } cmd_t;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchroniser, then majority filter paced by tickX16
    // ------------------------------------------------------------------
    logic [1:0]            sclSync, sdaSync;
    logic [FILTER_LEN-1:0] sclHist, sdaHist;
    logic                  sclF, sdaF;

    // NOTE: synchroniser and history reset to 1 so an idle (pulled-up) bus is
    // seen from the first cycle and no false START is detected out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
            sclHist <= '1;
            sdaHist <= '1;
        end else begin
            sclSync <= {sclSync[0], scl_in};
            sdaSync <= {sdaSync[0], sda_in};
            if (tickX16) begin
                for (int i = FILTER_LEN - 1; i > 0; i--) begin
                    sclHist[i] <= sclHist[i-1];
                    sdaHist[i] <= sdaHist[i-1];
                end
                sclHist[0] <= sclSync[1];
                sdaHist[0] <= sdaSync[1];
            end
        end
    end

    function automatic logic majority(input logic [FILTER_LEN-1:0] h);
        int ones;
        ones = 0;
        for (int i = 0; i < FILTER_LEN; i++) begin
            ones += int'(h[i]);
        end
        return ones > (FILTER_LEN / 2);
    endfunction

    assign sclF = majority(sclHist);
    assign sdaF = majority(sdaHist);

    // ------------------------------------------------------------------
    // Bus-busy tracking on filtered START/STOP conditions
    // ------------------------------------------------------------------
    logic sclFPrev, sdaFPrev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclFPrev <= 1'b1;
            sdaFPrev <= 1'b1;
            bus_busy <= 1'b0;
        end else begin
            sclFPrev <= sclF;
            sdaFPrev <= sdaF;
            // SCL must be high on both sides of the SDA edge to count.
            if (sclF && sclFPrev && sdaFPrev && !sdaF) begin
                bus_busy <= 1'b1;
            end else if (sclF && sclFPrev && !sdaFPrev && sdaF) begin
                bus_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    state_t state, stateNext;
    cmd_t   cmdReg, cmdNext;
    logic   wrBitReg, wrBitNext;
    logic   rdBitReg, rdBitNext;
    logic   doneReg, doneNext;
    logic   arbLostReg, arbLostNext;
    logic   sclOeReg, sclOeNext;
    logic   sdaOeReg, sdaOeNext;

    // Returns {scl_oe, sda_oe} for a quarter; 1 means drive the line low.
    function automatic logic [1:0] lineLevels(input cmd_t c, input state_t q, input logic w);
        logic [1:0] lv;
        lv = 2'b00;
        case (c)
            CMD_START: begin
                case (q)
                    Q2:      lv = 2'b01;
                    Q3:      lv = 2'b11;
                    default: lv = 2'b00;
                endcase
            end
            CMD_STOP: begin
                case (q)
                    Q0:      lv = 2'b11;
                    Q1, Q2:  lv = 2'b01;
                    default: lv = 2'b00;
                endcase
            end
            default: begin
                lv[1] = (q == Q0) || (q == Q3);
                lv[0] = (c == CMD_WRITE) ? !w : 1'b0;
            end
        endcase
        return lv;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmdReg     <= CMD_START;
            wrBitReg   <= 1'b0;
            rdBitReg   <= 1'b0;
            doneReg    <= 1'b0;
            arbLostReg <= 1'b0;
            sclOeReg   <= 1'b0;
            sdaOeReg   <= 1'b0;
        end else begin
            state      <= stateNext;
            cmdReg     <= cmdNext;
            wrBitReg   <= wrBitNext;
            rdBitReg   <= rdBitNext;
            doneReg    <= doneNext;
            arbLostReg <= arbLostNext;
            sclOeReg   <= sclOeNext;
            sdaOeReg   <= sdaOeNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        stateNext   = state;
        cmdNext     = cmdReg;
        wrBitNext   = wrBitReg;
        rdBitNext   = rdBitReg;
        doneNext    = 1'b0;
        arbLostNext = 1'b0;
        sclOeNext   = sclOeReg;
        sdaOeNext   = sdaOeReg;

        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmdNext   = cmd_t'(bus.cmd);
                    wrBitNext = bus.wr_bit;
                    stateNext = WAIT;
                end
            end
            WAIT: if (tickX4) stateNext = Q0;
            Q0:   if (tickX4) stateNext = Q1;
            Q1: begin
                // Ticks while a slave stretches SCL are simply dropped.
                if (tickX4 && sclF) begin
                    if (cmdReg == CMD_START && !sdaF) arbLostNext = 1'b1;
                    else                              stateNext   = Q2;
                end
            end
            Q2: begin
                if (tickX4) begin
                    rdBitNext = sdaF;
                    if (cmdReg == CMD_WRITE && wrBitReg && !sdaF) arbLostNext = 1'b1;
                    else                                          stateNext   = Q3;
                end
            end
            Q3: begin
                if (tickX4) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (arbLostNext) begin
            stateNext = IDLE;
            sclOeNext = 1'b0;
            sdaOeNext = 1'b0;
        end else if (stateNext != state && stateNext inside {Q0, Q1, Q2, Q3}) begin
            {sclOeNext, sdaOeNext} = lineLevels(cmdNext, stateNext, wrBitNext);
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.done      = doneReg;
    assign bus.rd_bit    = rdBitReg;
    assign bus.arb_lost  = arbLostReg;
    assign scl_oe        = sclOeReg;
    assign sda_oe        = sdaOeReg;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: open-drain pad model, slave/other-master
// drivers, and a scoreboard of expected command completions.
module tb_i2c_bit_ctrl;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;
    localparam logic [1:0] K_DONE  = 2'b10;
    localparam logic [1:0] K_ARB   = 2'b01;

    typedef struct {
        logic [1:0] kind;
        logic       chkRd;
        logic       rd;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] tickCnt = 3'd0;
    logic tickX4, tickX16, tickSeen = 1'b0;
    logic bus_busy, scl_oe, sda_oe, sclLine, sdaLine;
    logic slaveSclLow = 1'b0, slaveSdaLow = 1'b0, otherSdaLow = 1'b0, glitch = 1'b0;

    int   nChecks = 0;
    int   nFails  = 0;
    int   evtCnt  = 0;
    int   lat;
    exp_t sb[$];
    exp_t evt;

    i2c_bit_ctrl_if bus();

    i2c_bit_ctrl #(.FILTER_LEN(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tickX4   (tickX4),
        .tickX16  (tickX16),
        .bus      (bus),
        .bus_busy (bus_busy),
        .scl_in   (sclLine),
        .sda_in   (sdaLine),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tickCnt  <= tickCnt + 3'd1;
        tickSeen <= tickX4;
    end
    assign tickX4  = (tickCnt == 3'd7);
    assign tickX16 = tickCnt[0];

    assign sclLine = !(scl_oe || slaveSclLow);
    assign sdaLine = !(sda_oe || slaveSdaLow || otherSdaLow || glitch);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every done/arb_lost pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && (bus.done || bus.arb_lost)) begin
            evtCnt++;
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                evt = sb.pop_front();
                check({evt.tag, "_kind"}, {bus.done, bus.arb_lost}, evt.kind);
                if (evt.chkRd) check({evt.tag, "_rd"}, bus.rd_bit, evt.rd);
            end
        end
    end

    task automatic runCmd(input logic [1:0] c, input logic w, input string tag,
                          input logic chkLv, input logic [7:0] expLv,
                          input logic [1:0] kind, input logic chkRd, input logic rd,
                          output int cycles);
        logic [7:0] lv;
        int         nq, guard, n;
        exp_t       e;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, bus.cmd_ready, 1);
        e.kind = kind; e.chkRd = chkRd; e.rd = rd; e.tag = tag;
        sb.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.wr_bit    = w;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0; nq = 0; lv = 8'h00;
        forever begin
            @(negedge clk);
            n++;
            if (bus.done || bus.arb_lost || n >= 400) break;
            // Sample the levels set by each quarter-advancing tick.
            if (n > 1 && tickSeen && nq < 4) begin
                lv = {lv[5:0], scl_oe, sda_oe};
                nq++;
            end
        end
        cycles = n - 1;
        check({tag, "_no_timeout"}, n < 400, 1);
        if (chkLv) begin
            check({tag, "_levels"}, lv, expLv);
            check({tag, "_latency_ok"}, cycles >= 32 && cycles <= 40, 1);
        end
    endtask

    // Returns at the negedge right after the tick that enters Q2 (SCL-release + 1 tick).
    task automatic waitQ2(input string tag);
        int guard;
        guard = 0;
        while (!scl_oe && guard < 100) begin @(negedge clk); guard++; end
        while (scl_oe && guard < 200)  begin @(negedge clk); guard++; end
        do begin
            @(negedge clk);
            guard++;
        end while (!tickSeen && guard < 300);
        check({tag, "_q2_found"}, guard < 300, 1);
    endtask

    initial begin : stim
        logic sdaRef, stable, busySeen;
        int   base;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.wr_bit    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {bus.cmd_ready, bus.done, bus.rd_bit, bus.arb_lost,
                             bus_busy, scl_oe, sda_oe}, 7'b1000000);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1. START, WRITE 1, WRITE 0, STOP with quarter-level checks
        runCmd(C_START, 1'b0, "start", 1'b1, 8'b00_00_01_11, K_DONE, 1'b0, 1'b0, lat);
        check("start_busy", bus_busy, 1);
        runCmd(C_WRITE, 1'b1, "wr1", 1'b1, 8'b10_00_00_10, K_DONE, 1'b1, 1'b1, lat);
        runCmd(C_WRITE, 1'b0, "wr0", 1'b1, 8'b11_01_01_11, K_DONE, 1'b1, 1'b0, lat);
        runCmd(C_STOP,  1'b0, "stop", 1'b1, 8'b11_01_01_00, K_DONE, 1'b0, 1'b0, lat);
        repeat (10) @(negedge clk);
        check("stop_busy", bus_busy, 0);

        // 2. READs with slave holding SDA low, then released
        runCmd(C_START, 1'b0, "start2", 1'b1, 8'b00_00_01_11, K_DONE, 1'b0, 1'b0, lat);
        slaveSdaLow = 1'b1;
        runCmd(C_READ, 1'b0, "rd0", 1'b1, 8'b10_00_00_10, K_DONE, 1'b1, 1'b0, lat);
        slaveSdaLow = 1'b0;
        runCmd(C_READ, 1'b0, "rd1", 1'b1, 8'b10_00_00_10, K_DONE, 1'b1, 1'b1, lat);

        // 3. Clock stretching for 50 clk during WRITE Q1
        fork
            runCmd(C_WRITE, 1'b1, "stretch", 1'b0, 8'h00, K_DONE, 1'b1, 1'b1, lat);
            begin
                int guard;
                guard = 0;
                while (scl_oe && guard < 100) begin @(negedge clk); guard++; end
                slaveSclLow = 1'b1;
                sdaRef = sda_oe;
                stable = 1'b1;
                repeat (50) begin
                    @(negedge clk);
                    if (sda_oe !== sdaRef) stable = 1'b0;
                end
                slaveSclLow = 1'b0;
                check("stretch_sda_stable", stable, 1);
                check("stretch_sda_released", sdaRef, 0);
            end
        join
        check("stretch_latency", lat >= 80 && lat <= 110, 1);

        // 4. Arbitration loss: another master pulls SDA low in Q2 of WRITE 1
        fork
            runCmd(C_WRITE, 1'b1, "arb", 1'b0, 8'h00, K_ARB, 1'b0, 1'b0, lat);
            begin
                waitQ2("arb");
                otherSdaLow = 1'b1;
            end
        join
        check("arb_release_ready", {scl_oe, sda_oe, bus.cmd_ready}, 3'b001);
        repeat (3) @(negedge clk);
        otherSdaLow = 1'b0;
        repeat (20) @(negedge clk);
        check("arb_stop_busy", bus_busy, 0);

        // 5. Short SDA glitches while SCL is high
        busySeen = 1'b0;
        glitch = 1'b1;
        repeat (2) @(negedge clk);
        glitch = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busySeen |= bus_busy;
        end
        check("glitch_idle_busy", busySeen, 0);
        fork
            runCmd(C_READ, 1'b0, "glitch_rd", 1'b0, 8'h00, K_DONE, 1'b1, 1'b1, lat);
            begin
                waitQ2("glitch");
                repeat (3) @(negedge clk);
                glitch = 1'b1;
                repeat (2) @(negedge clk);
                glitch = 1'b0;
            end
        join
        check("glitch_rd_busy", bus_busy, 0);

        // 6. Asynchronous reset during WRITE 0 Q2
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd       = C_WRITE;
        bus.wr_bit    = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        waitQ2("rst");
        repeat (2) @(negedge clk);
        check("rst_pre_levels", {scl_oe, sda_oe}, 2'b01);
        base = evtCnt;
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_release", {scl_oe, sda_oe}, 2'b00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_no_events", evtCnt - base, 0);
        check("rst_outs", {bus.cmd_ready, bus.done, bus.arb_lost, scl_oe, sda_oe}, 5'b10000);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
